// File: rtl/ibex_multdiv_param.sv
// Parametrised multiply/divide unit for the RV M-extension.
// Multiply accumulates one Width x MulKernel partial product per cycle.
// Divide is restoring division, producing one quotient bit per cycle.
// Sign correction is applied combinationally to the registered magnitudes
// while the result is being presented.
module ibex_multdiv_param #(
  parameter int Width     = 32,
  parameter int MulKernel = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [2:0]       op_i,
  input  logic [Width-1:0] op_a_i,
  input  logic [Width-1:0] op_b_i,
  input  logic             data_ind_timing_i,
  input  logic             kill_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [Width-1:0] result_o
);

  localparam int NumMulIter = Width / MulKernel;
  localparam int CntW       = $clog2(Width + 1);

  typedef enum logic [1:0] {IDLE, MUL_ITER, DIV_ITER, DONE} state_e;

  state_e               state_q;
  logic [2:0]           op_q;
  logic                 sign_a_q;
  logic                 sign_b_q;
  logic                 div_zero_q;
  logic                 dit_q;
  logic [Width-1:0]     a_mag_q;
  logic [Width-1:0]     b_mag_q;
  logic [2*Width-1:0]   acc_q;
  logic [Width-1:0]     quot_q;
  logic [Width-1:0]     rem_q;
  logic [CntW-1:0]      cnt_q;

  logic                 signed_a_in;
  logic                 signed_b_in;
  logic                 sign_a_in;
  logic                 sign_b_in;
  logic [Width-1:0]     a_mag_in;
  logic [Width-1:0]     b_mag_in;

  int                   mul_shamt;
  logic [MulKernel-1:0] b_chunk;
  logic [Width+MulKernel-1:0] mul_prod;
  logic [2*Width-1:0]   mul_add;
  logic [Width:0]       div_shift;
  logic [Width:0]       div_trial;

  logic [2*Width-1:0]   prod_res;
  logic [Width-1:0]     quot_res;
  logic [Width-1:0]     rem_res;

  assign ready_o = (state_q == IDLE) && !kill_i;
  assign valid_o = (state_q == DONE);

  // Decode operand signedness and magnitudes of the incoming request; the most
  // negative value maps to its correct unsigned magnitude.
  always_comb begin
    signed_a_in = 1'b0;
    signed_b_in = 1'b0;
    case (op_i)
      3'd0, 3'd1, 3'd4, 3'd6: begin
        signed_a_in = 1'b1;
        signed_b_in = 1'b1;
      end
      3'd2:    signed_a_in = 1'b1;
      default: ;
    endcase
    sign_a_in = signed_a_in & op_a_i[Width-1];
    sign_b_in = signed_b_in & op_b_i[Width-1];
    a_mag_in  = sign_a_in ? -op_a_i : op_a_i;
    b_mag_in  = sign_b_in ? -op_b_i : op_b_i;
  end

  // One multiply step and one restoring-divide step. The partial remainder
  // is Width+1 bits wide only while the next dividend bit is shifted in.
  always_comb begin
    mul_shamt = int'(cnt_q) * MulKernel;
    b_chunk   = MulKernel'(b_mag_q >> mul_shamt);
    mul_prod  = {{MulKernel{1'b0}}, a_mag_q} * {{Width{1'b0}}, b_chunk};
    mul_add   = (2*Width)'(mul_prod) << mul_shamt;
    div_shift = {rem_q, quot_q[Width-1]};
    div_trial = div_shift - {1'b0, b_mag_q};
  end

  // Control FSM and datapath registers; kill has priority over everything
  // except reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      op_q       <= '0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      div_zero_q <= 1'b0;
      dit_q      <= 1'b0;
      a_mag_q    <= '0;
      b_mag_q    <= '0;
      acc_q      <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
    end else if (kill_i) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_i && ready_o) begin
            op_q       <= op_i;
            sign_a_q   <= sign_a_in;
            sign_b_q   <= sign_b_in;
            div_zero_q <= op_i[2] && (op_b_i == '0);
            dit_q      <= data_ind_timing_i;
            a_mag_q    <= a_mag_in;
            b_mag_q    <= b_mag_in;
            acc_q      <= '0;
            quot_q     <= a_mag_in;
            rem_q      <= '0;
            cnt_q      <= '0;
            state_q    <= op_i[2] ? DIV_ITER : MUL_ITER;
          end
        end
        MUL_ITER: begin
          acc_q <= acc_q + mul_add;
          cnt_q <= cnt_q + CntW'(1);
          if (cnt_q == CntW'(NumMulIter - 1)) state_q <= DONE;
        end
        DIV_ITER: begin
          if (div_zero_q && !dit_q) begin
            state_q <= DONE;
          end else begin
            rem_q  <= div_trial[Width] ? div_shift[Width-1:0] : div_trial[Width-1:0];
            quot_q <= {quot_q[Width-2:0], ~div_trial[Width]};
            cnt_q  <= cnt_q + CntW'(1);
            if (cnt_q == CntW'(Width - 1)) state_q <= DONE;
          end
        end
        DONE: begin
          if (ready_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Sign-correct the registered magnitudes and select the result; zero when idle.
  // A zero divisor forces all-ones quotient and the original dividend as remainder.
  always_comb begin
    prod_res = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
    if (div_zero_q) begin
      quot_res = '1;
      rem_res  = sign_a_q ? -a_mag_q : a_mag_q;
    end else begin
      quot_res = (sign_a_q ^ sign_b_q) ? -quot_q : quot_q;
      rem_res  = sign_a_q ? -rem_q : rem_q;
    end
    result_o = '0;
    if (state_q == DONE) begin
      case (op_q)
        3'd0:             result_o = prod_res[Width-1:0];
        3'd1, 3'd2, 3'd3: result_o = prod_res[2*Width-1:Width];
        3'd4, 3'd5:       result_o = quot_res;
        default:          result_o = rem_res;
      endcase
    end
  end

endmodule

// File: tb/tb_ibex_multdiv_param.sv
// Self-checking bench for ibex_multdiv_param (Width=32, MulKernel=16).
// A plain-arithmetic model predicts result and latency of each request;
// a per-cycle compare process checks valid_o, result_o and ready_o.
module tb_ibex_multdiv_param;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic        ready_o;
  logic [2:0]  op_i;
  logic [31:0] op_a_i;
  logic [31:0] op_b_i;
  logic        data_ind_timing_i;
  logic        kill_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] result_o;

  int          checks = 0;
  int          failures = 0;
  int          edge_cnt = 0;
  int          e0 = 0;
  int          exp_lat = 0;
  logic [31:0] exp_res = '0;
  logic        model_active = 1'b0;

  ibex_multdiv_param #(.Width(32), .MulKernel(16)) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .valid_i           (valid_i),
    .ready_o           (ready_o),
    .op_i              (op_i),
    .op_a_i            (op_a_i),
    .op_b_i            (op_b_i),
    .data_ind_timing_i (data_ind_timing_i),
    .kill_i            (kill_i),
    .valid_o           (valid_o),
    .ready_i           (ready_i),
    .result_o          (result_o)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk_i = ~clk_i;

  // Count rising edges so latencies can be measured from the accept edge.
  always @(posedge clk_i) edge_cnt++;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at t=%0t", name, actual, expected, $time);
    end
  endtask

  // Reference result of one M-extension operation on 32-bit operands.
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      ub;
    logic [63:0] p;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    ub = longint'({32'd0, b});
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        return 32'(int'(a) / int'(b));
      end
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
        return 32'(int'(a) % int'(b));
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int modelLatency(input logic [2:0] op, input logic [31:0] b,
                                      input logic dit);
    if (!op[2]) return 2;
    if (b == 0 && !dit) return 1;
    return 32;
  endfunction

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFFFFFF;
      3:       return 32'h80000000;
      4:       return 32'h7FFFFFFF;
      5:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Check every cycle: valid_o exactly from the predicted edge, result_o
  // stable while held and zero otherwise, ready_o only when idle and not killed.
  always @(negedge clk_i) begin
    logic ev;
    ev = model_active && ((edge_cnt - e0) >= exp_lat);
    checkOutput("valid_o", {31'd0, valid_o}, {31'd0, ev});
    checkOutput("result_o", result_o, ev ? exp_res : 32'd0);
    checkOutput("ready_o", {31'd0, ready_o}, {31'd0, (!model_active && !kill_i)});
  end

  // Issue one request, then either complete it (with hold cycles of
  // backpressure), kill it after kill_at edges, or reset after rst_at edges.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic dit, input int hold,
                               input int kill_at, input int rst_at);
    int guard;
    int lat;
    guard = 0;
    op_i = op;
    op_a_i = a;
    op_b_i = b;
    data_ind_timing_i = dit;
    valid_i = 1'b1;
    @(negedge clk_i);
    while (!ready_o && guard < 50) begin
      @(negedge clk_i);
      guard++;
    end
    if (!ready_o) begin
      checks++;
      failures++;
      $display("[TB] FAIL accept_wait actual=ready_o_low expected=ready_o_high");
      valid_i = 1'b0;
      return;
    end
    @(posedge clk_i);
    #1;
    lat = modelLatency(op, b, dit);
    exp_res = model(op, a, b);
    exp_lat = lat;
    e0 = edge_cnt;
    model_active = 1'b1;
    valid_i = 1'($urandom_range(0, 1));
    op_i = 3'($urandom);
    op_a_i = $urandom;
    op_b_i = $urandom;
    data_ind_timing_i = 1'($urandom);
    ready_i = 1'($urandom);
    if (kill_at >= 0) begin
      repeat (kill_at) @(posedge clk_i);
      #1 kill_i = 1'b1;
      @(posedge clk_i);
      #1 kill_i = 1'b0;
      valid_i = 1'b0;
      model_active = 1'b0;
      return;
    end
    if (rst_at >= 0) begin
      repeat (rst_at) @(posedge clk_i);
      #1 valid_i = 1'b0;
      rst_i = 1'b1;
      model_active = 1'b0;
      #1;
      checkOutput("rst_valid", {31'd0, valid_o}, 32'd0);
      checkOutput("rst_result", result_o, 32'd0);
      checkOutput("rst_ready", {31'd0, ready_o}, 32'd1);
      @(posedge clk_i);
      #1 rst_i = 1'b0;
      return;
    end
    repeat (lat) @(posedge clk_i);
    #1 valid_i = 1'b0;
    ready_i = 1'b0;
    repeat (hold) begin
      @(posedge clk_i);
      #1;
    end
    ready_i = 1'b1;
    @(posedge clk_i);
    #1 ready_i = 1'b0;
    model_active = 1'b0;
  endtask

  initial begin
    int kill_at;
    logic [2:0] op;
    logic [31:0] b;
    logic dit;
    rst_i = 1'b1;
    valid_i = 1'b0;
    op_i = '0;
    op_a_i = '0;
    op_b_i = '0;
    data_ind_timing_i = 1'b0;
    kill_i = 1'b0;
    ready_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("reset_valid", {31'd0, valid_o}, 32'd0);
    checkOutput("reset_result", result_o, 32'd0);
    checkOutput("reset_ready", {31'd0, ready_o}, 32'd1);
    rst_i = 1'b0;

    // Hand-computed values that pin the reference model.
    checkOutput("pin_mul", model(3'd0, 32'd7, 32'hFFFFFFFD), 32'hFFFFFFEB);
    checkOutput("pin_mulh", model(3'd1, 32'h80000000, 32'h80000000), 32'h40000000);
    checkOutput("pin_mulhu", model(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF), 32'hFFFFFFFE);
    checkOutput("pin_mulhsu", model(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF), 32'hFFFFFFFF);
    checkOutput("pin_div", model(3'd4, 32'hFFFFFFF9, 32'd2), 32'hFFFFFFFD);
    checkOutput("pin_rem", model(3'd6, 32'hFFFFFFF9, 32'd2), 32'hFFFFFFFF);
    checkOutput("pin_divu0", model(3'd5, 32'd5, 32'd0), 32'hFFFFFFFF);
    checkOutput("pin_remu0", model(3'd7, 32'd5, 32'd0), 32'd5);
    checkOutput("pin_divovf", model(3'd4, 32'h80000000, 32'hFFFFFFFF), 32'h80000000);
    checkOutput("pin_removf", model(3'd6, 32'h80000000, 32'hFFFFFFFF), 32'd0);
    checkOutput("pin_lat_mul", 32'(modelLatency(3'd0, 32'd3, 1'b0)), 32'd2);
    checkOutput("pin_lat_div0", 32'(modelLatency(3'd5, 32'd0, 1'b0)), 32'd1);

    // Directed cases from the test plan.
    applyStimulus(3'd0, 32'd7, 32'hFFFFFFFD, 1'b0, 0, -1, -1);
    applyStimulus(3'd1, 32'h80000000, 32'h80000000, 1'b0, 0, -1, -1);
    applyStimulus(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1, -1, -1);
    applyStimulus(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 0, -1, -1);
    applyStimulus(3'd4, 32'hFFFFFFF9, 32'd2, 1'b0, 0, -1, -1);
    applyStimulus(3'd6, 32'hFFFFFFF9, 32'd2, 1'b0, 0, -1, -1);
    applyStimulus(3'd5, 32'd5, 32'd0, 1'b0, 0, -1, -1);
    applyStimulus(3'd7, 32'd5, 32'd0, 1'b0, 0, -1, -1);
    applyStimulus(3'd5, 32'd5, 32'd0, 1'b1, 0, -1, -1);
    applyStimulus(3'd7, 32'd5, 32'd0, 1'b1, 0, -1, -1);
    applyStimulus(3'd4, 32'h80000000, 32'hFFFFFFFF, 1'b0, 5, -1, -1);
    applyStimulus(3'd6, 32'h80000000, 32'hFFFFFFFF, 1'b0, 5, -1, -1);
    applyStimulus(3'd4, 32'h12345678, 32'd7, 1'b0, 0, -1, 10);
    applyStimulus(3'd0, 32'h12345678, 32'h9ABCDEF0, 1'b0, 0, 1, -1);
    applyStimulus(3'd0, 32'h12345678, 32'h9ABCDEF0, 1'b0, 0, -1, -1);

    // Randomized requests with occasional kills and backpressure.
    for (int i = 0; i < 300; i++) begin
      op = 3'($urandom);
      b = pickOperand();
      dit = 1'($urandom);
      kill_at = -1;
      if ($urandom_range(0, 15) == 0)
        kill_at = $urandom_range(0, modelLatency(op, b, dit) - 1);
      applyStimulus(op, pickOperand(), b, dit, $urandom_range(0, 3), kill_at, -1);
    end

    repeat (2) @(posedge clk_i);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
